// File: rtl/dsp_pkg.sv
// Shared opcode constants, ALU function codes and sequencer states for the 16-bit DSP core.
package dsp_pkg;

  typedef enum logic [2:0] {
    ALU_NOP   = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_LOAD  = 3'd2,
    ALU_LOADK = 3'd3,
    ALU_ZERO  = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_FETCH2 = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [15:0] IR_NOP  = 16'h7F80;
  localparam logic [15:0] IR_ZAC  = 16'h7F89;
  localparam logic [15:0] IR_HALT = 16'hFFFF;

  // Shift-class opcodes decode on the top nibble, the rest on the top byte.
  localparam logic [3:0] OP4_ADD  = 4'h0;
  localparam logic [3:0] OP4_LAC  = 4'h2;
  localparam logic [7:0] OP8_SACL = 8'h50;
  localparam logic [7:0] OP8_LACK = 8'h7E;
  localparam logic [7:0] OP8_B    = 8'hF9;
  localparam logic [7:0] OP8_BZ   = 8'hF6;

endpackage

// File: rtl/dsp_op_classify.sv
// Combinational instruction classifier: maps one instruction word to its execution class.
module dsp_op_classify
  import dsp_pkg::*;
(
  input  logic [15:0] word_i,
  output logic        two_word_o,
  output logic        is_bz_o,
  output logic        needs_read_o,
  output logic        is_store_o,
  output logic        is_halt_o,
  output logic [2:0]  alu_op_o
);

  always_comb begin
    two_word_o   = 1'b0;
    is_bz_o      = 1'b0;
    needs_read_o = 1'b0;
    is_store_o   = 1'b0;
    is_halt_o    = 1'b0;
    alu_op_o     = ALU_NOP;
    // Unrecognised words fall through every arm and execute as NOP.
    if (word_i[15:12] == OP4_ADD) begin
      needs_read_o = 1'b1;
      alu_op_o     = ALU_ADD;
    end else if (word_i[15:12] == OP4_LAC) begin
      needs_read_o = 1'b1;
      alu_op_o     = ALU_LOAD;
    end else if (word_i[15:8] == OP8_SACL) begin
      is_store_o = 1'b1;
    end else if (word_i[15:8] == OP8_LACK) begin
      alu_op_o = ALU_LOADK;
    end else if (word_i == IR_ZAC) begin
      alu_op_o = ALU_ZERO;
    end else if (word_i[15:8] == OP8_B) begin
      two_word_o = 1'b1;
    end else if (word_i[15:8] == OP8_BZ) begin
      two_word_o = 1'b1;
      is_bz_o    = 1'b1;
    end else if (word_i == IR_HALT) begin
      is_halt_o = 1'b1;
    end
  end

endmodule

// File: rtl/dsp_sequencer.sv
// Fetch/execute sequencer: owns PC and IR, fetches over a valid-qualified port, drives ALU/dmem strobes.
module dsp_sequencer
  import dsp_pkg::*;
#(
  parameter int unsigned       PC_W      = 12,
  parameter logic [PC_W-1:0]   RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [15:0]     ir,
  input  logic            acc_zero,
  output logic [2:0]      alu_op,
  output logic            acc_we,
  output logic            dmem_re,
  output logic            dmem_we,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [15:0]     ir_q, ir_d;

  logic [15:0] cls_word;
  logic        c_two_word, c_is_bz, c_needs_read, c_is_store, c_is_halt;
  logic [2:0]  c_alu_op;
  logic        in_exec, fetch_ok;

  // One classifier is shared: in FETCH it looks at the incoming word to pick the
  // next state, everywhere else it decodes the held IR for execution.
  assign cls_word = (state_q == ST_FETCH) ? imem_data : ir_q;

  dsp_op_classify u_classify (
    .word_i       (cls_word),
    .two_word_o   (c_two_word),
    .is_bz_o      (c_is_bz),
    .needs_read_o (c_needs_read),
    .is_store_o   (c_is_store),
    .is_halt_o    (c_is_halt),
    .alu_op_o     (c_alu_op)
  );

  assign imem_req  = ((state_q == ST_FETCH) || (state_q == ST_FETCH2)) && !reset;
  assign fetch_ok  = imem_req && imem_valid;
  assign imem_addr = pc_q;
  assign ir        = ir_q;

  assign in_exec = (state_q == ST_EXEC) && !reset;
  assign acc_we  = in_exec && (c_alu_op != ALU_NOP);
  assign alu_op  = acc_we ? c_alu_op : ALU_NOP;
  assign dmem_we = in_exec && c_is_store;
  assign dmem_re = (state_q == ST_READ) && !reset;
  assign halted  = (state_q == ST_HALT) && !reset;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    ir_d     = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (fetch_ok) begin
          ir_d = imem_data;
          pc_d = pc_q + PC_W'(1);
          if (c_two_word)        state_d = ST_FETCH2;
          else if (c_needs_read) state_d = ST_READ;
          else if (c_is_halt)    state_d = ST_HALT;
          else                   state_d = ST_EXEC;
        end
      end
      ST_FETCH2: begin
        if (fetch_ok) begin
          target_d = imem_data[PC_W-1:0];
          pc_d     = pc_q + PC_W'(1);
          state_d  = ST_EXEC;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        if (c_two_word && (!c_is_bz || acc_zero)) pc_d = target_q;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_VEC;
      target_q <= '0;
      ir_q     <= IR_NOP;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      ir_q     <= ir_d;
    end
  end

endmodule
